// File: rtl/vertex_transform.sv
// vertex_transform: applies a double-buffered 4x4 view-projection matrix to
// model-space vertices (w forced to 1.0) and emits clip-space positions.
// All four output components share one fp32_dot instance, issued row by row.
//
// fp32_dot: 4-element fp32 dot product, fixed latency of 3 cycles, in-order.
// Arithmetic is simplified: denormals flush to zero, results truncate
// (round toward zero), NaN is not propagated distinctly from infinity.

module fp32_dot (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    input  logic [3:0][31:0] a_in,
    input  logic [3:0][31:0] b_in,
    output logic             valid_out,
    output logic [31:0]      c_out
);
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] prod;
        logic [22:0] m;
        logic        s;
        int          e;
        logic [31:0] r;
        s    = a[31] ^ b[31];
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e    = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            m = prod[46:24];
            e = e + 1;
        end else begin
            m = prod[45:23];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            r = {s, 31'd0};
        else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF || e >= 255)
            r = {s, 8'hFF, 23'd0};
        else if (e <= 0)
            r = {s, 31'd0};
        else
            r = {s, e[7:0], m};
        return r;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, r;
        logic [26:0] mx, my, sum;
        logic [7:0]  d;
        int          e, pos;
        // x is the operand of larger magnitude
        if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        d   = x[30:23] - y[30:23];
        mx  = {2'b01, x[22:0], 2'b00};
        my  = {2'b01, y[22:0], 2'b00};
        my  = (d > 8'd26) ? 27'd0 : (my >> d);
        e   = int'(x[30:23]);
        pos = 0;
        sum = 27'd0;
        r   = x;
        if (y[30:23] == 8'd0 || x[30:23] == 8'hFF) begin
            r = x;
        end else if (x[31] == y[31]) begin
            sum = mx + my;
            if (sum[26]) begin
                e = e + 1;
                r = {x[31], e[7:0], sum[25:3]};
            end else begin
                r = {x[31], x[30:23], sum[24:2]};
            end
            if (e >= 255)
                r = {x[31], 8'hFF, 23'd0};
        end else begin
            sum = mx - my;
            for (int i = 0; i < 26; i++)
                if (sum[i]) pos = i;
            if (sum == 27'd0 || (25 - pos) >= e) begin
                r = 32'd0;
            end else begin
                sum = sum << (25 - pos);
                e   = e - (25 - pos);
                r   = {x[31], e[7:0], sum[24:2]};
            end
        end
        return r;
    endfunction

    logic [3:0][31:0] prod_reg;
    logic [1:0][31:0] pair_reg;
    logic [31:0]      sum_reg;
    logic             v1_reg, v2_reg, v3_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mul
            // stage 1: one multiplier per element pair
            always_ff @(posedge clk_in)
                prod_reg[gi] <= fp_mul(a_in[gi], b_in[gi]);
        end
        for (gi = 0; gi < 2; gi++) begin : g_add
            // stage 2: pairwise sums
            always_ff @(posedge clk_in)
                pair_reg[gi] <= fp_add(prod_reg[2*gi], prod_reg[2*gi+1]);
        end
    endgenerate

    // stage 3: final sum
    always_ff @(posedge clk_in)
        sum_reg <= fp_add(pair_reg[0], pair_reg[1]);

    // valid pipeline tracking the three data stages
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else begin
            v1_reg <= valid_in;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
        end
    end

    assign valid_out = v3_reg;
    assign c_out     = sum_reg;
endmodule

module vertex_transform #(
    parameter logic [31:0] W_ONE = 32'h3F800000
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             mat_valid_in,
    input  logic [3:0][31:0] mat_col_in,
    input  logic             vtx_valid_in,
    output logic             vtx_ready_out,
    input  logic [2:0][31:0] vtx_in,
    output logic             pos_valid_out,
    input  logic             pos_ready_in,
    output logic [3:0][31:0] pos_out
);
    localparam logic [2:0] ST_NOMATRIX = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_COLLECT  = 3'd3;
    localparam logic [2:0] ST_OUTPUT   = 3'd4;

    // matrices stored column-major: [col][row]
    logic [3:0][3:0][31:0] shadow_reg, shadow_next;
    logic [3:0][3:0][31:0] active_reg, active_next;
    logic [3:0][31:0]      vtx_reg, vtx_next;
    logic [3:0][31:0]      result_reg, result_next;
    logic [3:0][31:0]      pos_reg, pos_next;
    logic [3:0][31:0]      dot_a_reg, dot_a_next;
    logic [3:0][31:0]      dot_b_reg, dot_b_next;
    logic [2:0]            state_reg, state_next;
    logic [1:0]            col_cnt_reg, col_cnt_next;
    logic [1:0]            issue_idx_reg, issue_idx_next;
    logic [1:0]            collect_idx_reg, collect_idx_next;
    logic                  swap_pending_reg, swap_pending_next;
    logic                  mat_ok_reg, mat_ok_next;
    logic                  pos_valid_reg, pos_valid_next;
    logic                  vtx_ready_reg, vtx_ready_next;
    logic                  dot_valid_reg, dot_valid_next;
    logic                  dot_valid_out;
    logic [31:0]           dot_c;
    logic                  swap;

    fp32_dot u_dot (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .valid_in  (dot_valid_reg),
        .a_in      (dot_a_reg),
        .b_in      (dot_b_reg),
        .valid_out (dot_valid_out),
        .c_out     (dot_c)
    );

    // next-state: matrix load/swap, vertex FSM, dot issue and result collection
    always_comb begin
        shadow_next       = shadow_reg;
        active_next       = active_reg;
        vtx_next          = vtx_reg;
        result_next       = result_reg;
        pos_next          = pos_reg;
        dot_a_next        = dot_a_reg;
        dot_b_next        = dot_b_reg;
        state_next        = state_reg;
        col_cnt_next      = col_cnt_reg;
        issue_idx_next    = issue_idx_reg;
        collect_idx_next  = collect_idx_reg;
        swap_pending_next = swap_pending_reg;
        mat_ok_next       = mat_ok_reg;
        pos_valid_next    = pos_valid_reg;
        dot_valid_next    = 1'b0;

        // active bank only changes while no vertex is in flight
        swap = ((state_reg == ST_NOMATRIX) || (state_reg == ST_IDLE)) && swap_pending_reg;
        if (swap) begin
            active_next       = shadow_reg;
            mat_ok_next       = 1'b1;
            swap_pending_next = 1'b0;
        end

        // a completing beat re-arms the swap even if one fires this edge
        if (mat_valid_in) begin
            shadow_next[col_cnt_reg] = mat_col_in;
            col_cnt_next             = col_cnt_reg + 2'd1;
            if (col_cnt_reg == 2'd3)
                swap_pending_next = 1'b1;
        end

        case (state_reg)
            ST_NOMATRIX: begin
                if (swap)
                    state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (vtx_valid_in && vtx_ready_reg) begin
                    vtx_next       = {W_ONE, vtx_in[2], vtx_in[1], vtx_in[0]};
                    issue_idx_next = 2'd0;
                    state_next     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dot_valid_next = 1'b1;
                for (int j = 0; j < 4; j++)
                    dot_a_next[j] = active_reg[j][issue_idx_reg];
                dot_b_next     = vtx_reg;
                issue_idx_next = issue_idx_reg + 2'd1;
                if (issue_idx_reg == 2'd3) begin
                    collect_idx_next = 2'd0;
                    state_next       = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (dot_valid_out) begin
                    result_next[collect_idx_reg] = dot_c;
                    collect_idx_next             = collect_idx_reg + 2'd1;
                    if (collect_idx_reg == 2'd3) begin
                        pos_next       = result_next;
                        pos_valid_next = 1'b1;
                        state_next     = ST_OUTPUT;
                    end
                end
            end
            ST_OUTPUT: begin
                if (pos_ready_in) begin
                    pos_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_NOMATRIX;
        endcase

        vtx_ready_next = (state_next == ST_IDLE) && !swap_pending_next && mat_ok_next;
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_reg       <= '0;
            active_reg       <= '0;
            vtx_reg          <= '0;
            result_reg       <= '0;
            pos_reg          <= '0;
            dot_a_reg        <= '0;
            dot_b_reg        <= '0;
            state_reg        <= ST_NOMATRIX;
            col_cnt_reg      <= 2'd0;
            issue_idx_reg    <= 2'd0;
            collect_idx_reg  <= 2'd0;
            swap_pending_reg <= 1'b0;
            mat_ok_reg       <= 1'b0;
            pos_valid_reg    <= 1'b0;
            vtx_ready_reg    <= 1'b0;
            dot_valid_reg    <= 1'b0;
        end else begin
            shadow_reg       <= shadow_next;
            active_reg       <= active_next;
            vtx_reg          <= vtx_next;
            result_reg       <= result_next;
            pos_reg          <= pos_next;
            dot_a_reg        <= dot_a_next;
            dot_b_reg        <= dot_b_next;
            state_reg        <= state_next;
            col_cnt_reg      <= col_cnt_next;
            issue_idx_reg    <= issue_idx_next;
            collect_idx_reg  <= collect_idx_next;
            swap_pending_reg <= swap_pending_next;
            mat_ok_reg       <= mat_ok_next;
            pos_valid_reg    <= pos_valid_next;
            vtx_ready_reg    <= vtx_ready_next;
            dot_valid_reg    <= dot_valid_next;
        end
    end

    assign vtx_ready_out = vtx_ready_reg;
    assign pos_valid_out = pos_valid_reg;
    assign pos_out       = pos_reg;
endmodule

// File: tb/tb_vertex_transform.sv
// Directed bench for vertex_transform: identity, translation, backpressure,
// matrix double-buffering, reset mid-issue and partial matrix loads.

module tb_vertex_transform;
    localparam logic [31:0] F0 = 32'h00000000;
    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000;
    localparam logic [31:0] F5 = 32'h40A00000;
    localparam logic [31:0] F6 = 32'h40C00000;
    localparam int DOT_LAT = 3;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b1;
    logic             mat_valid_in = 1'b0;
    logic [3:0][31:0] mat_col_in = '0;
    logic             vtx_valid_in = 1'b0;
    logic             vtx_ready_out;
    logic [2:0][31:0] vtx_in = '0;
    logic             pos_valid_out;
    logic             pos_ready_in = 1'b1;
    logic [3:0][31:0] pos_out;

    int checks = 0;
    int failures = 0;

    logic [3:0][3:0][31:0] m_ident, m_trans, m_diag;
    logic [2:0][31:0]      v123;
    logic [3:0][31:0]      exp_ident, exp_trans, exp_diag;

    vertex_transform dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .mat_valid_in  (mat_valid_in),
        .mat_col_in    (mat_col_in),
        .vtx_valid_in  (vtx_valid_in),
        .vtx_ready_out (vtx_ready_out),
        .vtx_in        (vtx_in),
        .pos_valid_out (pos_valid_out),
        .pos_ready_in  (pos_ready_in),
        .pos_out       (pos_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic load_matrix(input logic [3:0][3:0][31:0] m);
        for (int j = 0; j < 4; j++) begin
            mat_valid_in = 1'b1;
            mat_col_in   = m[j];
            step(1);
        end
        mat_valid_in = 1'b0;
        mat_col_in   = '0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (vtx_ready_out) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic send_vertex(input logic [2:0][31:0] v);
        vtx_valid_in = 1'b1;
        vtx_in       = v;
        step(1);
        vtx_valid_in = 1'b0;
    endtask

    task automatic wait_pos(output int cycles);
        cycles = 0;
        while (!pos_valid_out && cycles < 60) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n_in = 1'b0;
        step(2);
        checks++; if (pos_valid_out !== 1'b0) begin failures++; $display("FAIL reset_pos_valid: got %b expected 0", pos_valid_out); end
        checks++; if (vtx_ready_out !== 1'b0) begin failures++; $display("FAIL reset_vtx_ready: got %b expected 0", vtx_ready_out); end
        checks++; if (pos_out !== '0) begin failures++; $display("FAIL reset_pos_out: got %h expected 0", pos_out); end
        rst_n_in = 1'b1;
        step(3);
        checks++; if (vtx_ready_out !== 1'b0) begin failures++; $display("FAIL nomatrix_ready: got %b expected 0", vtx_ready_out); end
        $display("reset: done");
    endtask

    task automatic test_identity();
        bit ok;
        int cyc;
        load_matrix(m_ident);
        wait_ready(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ident_ready: got 0 expected 1 within 20 cycles"); end
        send_vertex(v123);
        wait_pos(cyc);
        checks++; if (pos_valid_out !== 1'b1) begin failures++; $display("FAIL ident_valid: got %b expected 1", pos_valid_out); end
        checks++; if (cyc != DOT_LAT + 5) begin failures++; $display("FAIL ident_latency: got %0d expected %0d", cyc, DOT_LAT + 5); end
        checks++; if (pos_out !== exp_ident) begin failures++; $display("FAIL ident_pos: got %h expected %h", pos_out, exp_ident); end
        step(1);
        checks++; if (pos_valid_out !== 1'b0) begin failures++; $display("FAIL ident_single_beat: got %b expected 0", pos_valid_out); end
        checks++; if (vtx_ready_out !== 1'b1) begin failures++; $display("FAIL ident_ready_after: got %b expected 1", vtx_ready_out); end
        $display("identity: pos=%h latency=%0d", exp_ident, cyc);
    endtask

    task automatic test_translation();
        bit ok;
        int cyc;
        load_matrix(m_trans);
        wait_ready(ok);
        checks++; if (!ok) begin failures++; $display("FAIL trans_ready: got 0 expected 1 within 20 cycles"); end
        send_vertex(v123);
        wait_pos(cyc);
        checks++; if (pos_out[0] !== F6) begin failures++; $display("FAIL trans_x: got %h expected %h", pos_out[0], F6); end
        checks++; if (pos_out[1] !== F2) begin failures++; $display("FAIL trans_y: got %h expected %h", pos_out[1], F2); end
        checks++; if (pos_out[2] !== F3) begin failures++; $display("FAIL trans_z: got %h expected %h", pos_out[2], F3); end
        checks++; if (pos_out[3] !== F1) begin failures++; $display("FAIL trans_w: got %h expected %h", pos_out[3], F1); end
        step(1);
        $display("translation: pos=%h", exp_trans);
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        pos_ready_in = 1'b0;
        wait_ready(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_ready: got 0 expected 1 within 20 cycles"); end
        send_vertex(v123);
        wait_pos(cyc);
        checks++; if (pos_valid_out !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", pos_valid_out); end
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++; if (pos_valid_out !== 1'b1) begin failures++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", i, pos_valid_out); end
            checks++; if (pos_out !== exp_trans) begin failures++; $display("FAIL bp_hold_pos: cycle %0d got %h expected %h", i, pos_out, exp_trans); end
            checks++; if (vtx_ready_out !== 1'b0) begin failures++; $display("FAIL bp_hold_ready: cycle %0d got %b expected 0", i, vtx_ready_out); end
        end
        pos_ready_in = 1'b1;
        step(1);
        checks++; if (pos_valid_out !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", pos_valid_out); end
        checks++; if (vtx_ready_out !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", vtx_ready_out); end
        $display("backpressure: held 10 cycles, pos=%h", exp_trans);
    endtask

    task automatic test_double_buffer();
        bit ok;
        int cyc;
        load_matrix(m_ident);
        wait_ready(ok);
        checks++; if (!ok) begin failures++; $display("FAIL dbuf_ready0: got 0 expected 1 within 20 cycles"); end
        pos_ready_in = 1'b0;
        send_vertex(v123);
        step(3);
        load_matrix(m_diag);
        wait_pos(cyc);
        checks++; if (pos_out !== exp_ident) begin failures++; $display("FAIL dbuf_inflight_pos: got %h expected %h", pos_out, exp_ident); end
        pos_ready_in = 1'b1;
        step(1);
        checks++; if (vtx_ready_out !== 1'b0) begin failures++; $display("FAIL dbuf_swap_gate: got %b expected 0", vtx_ready_out); end
        wait_ready(ok);
        checks++; if (!ok) begin failures++; $display("FAIL dbuf_ready1: got 0 expected 1 within 20 cycles"); end
        send_vertex(v123);
        wait_pos(cyc);
        checks++; if (pos_out !== exp_diag) begin failures++; $display("FAIL dbuf_new_pos: got %h expected %h", pos_out, exp_diag); end
        step(1);
        $display("double_buffer: first=%h second=%h", exp_ident, exp_diag);
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        wait_ready(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_ready: got 0 expected 1 within 20 cycles"); end
        send_vertex(v123);
        rst_n_in = 1'b0;
        #1;
        checks++; if (pos_valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0", pos_valid_out); end
        checks++; if (vtx_ready_out !== 1'b0) begin failures++; $display("FAIL rst_mid_ready: got %b expected 0", vtx_ready_out); end
        checks++; if (pos_out !== '0) begin failures++; $display("FAIL rst_mid_pos: got %h expected 0", pos_out); end
        step(2);
        rst_n_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            checks++; if (vtx_ready_out !== 1'b0 || pos_valid_out !== 1'b0) begin failures++; $display("FAIL rst_post: cycle %0d ready=%b valid=%b expected 0 0", i, vtx_ready_out, pos_valid_out); end
        end
        $display("reset_mid_issue: outputs cleared");
    endtask

    task automatic test_partial_load();
        bit ok;
        int cyc;
        vtx_valid_in = 1'b1;
        vtx_in       = v123;
        for (int j = 0; j < 3; j++) begin
            mat_valid_in = 1'b1;
            mat_col_in   = m_diag[j];
            step(1);
        end
        mat_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (vtx_ready_out !== 1'b0) begin failures++; $display("FAIL partial_ready: cycle %0d got %b expected 0", i, vtx_ready_out); end
        end
        vtx_valid_in = 1'b0;
        mat_valid_in = 1'b1;
        mat_col_in   = m_diag[3];
        step(1);
        mat_valid_in = 1'b0;
        mat_col_in   = '0;
        ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1);
            if (vtx_ready_out) ok = 1'b1;
        end
        checks++; if (!ok) begin failures++; $display("FAIL partial_4th_ready: got 0 expected 1 within 2 cycles"); end
        checks++; if (pos_valid_out !== 1'b0) begin failures++; $display("FAIL partial_ignored_vtx: got %b expected 0", pos_valid_out); end
        send_vertex(v123);
        wait_pos(cyc);
        checks++; if (pos_out !== exp_diag) begin failures++; $display("FAIL partial_pos: got %h expected %h", pos_out, exp_diag); end
        step(1);
        $display("partial_load: pos=%h", exp_diag);
    endtask

    initial begin
        m_ident[0] = {F0, F0, F0, F1};
        m_ident[1] = {F0, F0, F1, F0};
        m_ident[2] = {F0, F1, F0, F0};
        m_ident[3] = {F1, F0, F0, F0};
        m_trans    = m_ident;
        m_trans[3] = {F1, F0, F0, F5};
        m_diag[0]  = {F0, F0, F0, F2};
        m_diag[1]  = {F0, F0, F2, F0};
        m_diag[2]  = {F0, F2, F0, F0};
        m_diag[3]  = {F1, F0, F0, F0};
        v123       = {F3, F2, F1};
        exp_ident  = {F1, F3, F2, F1};
        exp_trans  = {F1, F3, F2, F6};
        exp_diag   = {F1, F6, F4, F2};

        test_reset();
        test_identity();
        test_translation();
        test_backpressure();
        test_double_buffer();
        test_reset_mid_issue();
        test_partial_load();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
